// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: default width, FSM states and the response record.
package gcd_pkg;

  localparam int unsigned GcdW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } gcd_state_e;

  typedef struct packed {
    logic [GcdW-1:0] a;
    logic [GcdW-1:0] b;
    logic [GcdW-1:0] gcd;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_rsp_fifo.sv
// Response FIFO with registered head, no fall-through; pointers wrap modulo DEPTH.
module gcd_rsp_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = gcd_rsp_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the GCD engine: one request outstanding, FIFO slot reserved at accept,
// a==0 answered locally since the engine would never terminate on it.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned W     = GcdW,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  output logic         req_ready,
  input  logic         req_valid,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         gcd_in_ready,
  output logic         gcd_in_valid,
  output logic [W-1:0] gcd_in_a,
  output logic [W-1:0] gcd_in_b,
  input  logic         gcd_out_valid,
  input  logic [W-1:0] gcd_out_bits,
  input  logic         rsp_ready,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_a,
  output logic [W-1:0] rsp_b,
  output logic [W-1:0] rsp_gcd,
  output logic         busy,
  output logic         err,
  output logic [15:0]  done_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] gcd;
  } rsp_t;

  gcd_state_e    state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [CW-1:0] count;
  rsp_t          push_data;
  rsp_t          head;
  logic          accept;
  logic          bypass;
  logic          eng_push;
  logic          push;
  logic          pop;

  assign req_ready = (state == StIdle) && (count < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign bypass    = accept && (req_a == '0);
  assign eng_push  = (state == StWait) && gcd_out_valid;
  assign push      = bypass || eng_push;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    push_data = '{a: op_a, b: op_b, gcd: gcd_out_bits};
    if (bypass) begin
      push_data = '{a: req_a, b: req_b, gcd: req_b};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      op_a       <= '0;
      op_b       <= '0;
      err        <= 1'b0;
      done_count <= '0;
    end else begin
      if (push) begin
        done_count <= done_count + 16'd1;
      end
      // The engine only answers in WAIT; anything else is a protocol violation.
      if (gcd_out_valid && (state != StWait)) begin
        err <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (accept) begin
            op_a <= req_a;
            op_b <= req_b;
            if (req_a != '0) begin
              state <= StIssue;
            end
          end
        end
        StIssue: begin
          if (gcd_in_ready) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (gcd_out_valid) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign gcd_in_valid = (state == StIssue);
  assign gcd_in_a     = op_a;
  assign gcd_in_b     = op_b;
  assign busy         = (state != StIdle);
  assign rsp_valid    = (count != '0);
  assign rsp_a        = head.a;
  assign rsp_b        = head.b;
  assign rsp_gcd      = head.gcd;

  gcd_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (rsp_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_gcd_requester.sv
// Directed and randomized bench for gcd_requester against a queue-based reference model.
module tb_gcd_requester;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_ready;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         gcd_in_ready = 1'b0;
  logic         gcd_in_valid;
  logic [W-1:0] gcd_in_a;
  logic [W-1:0] gcd_in_b;
  logic         gcd_out_valid = 1'b0;
  logic [W-1:0] gcd_out_bits = '0;
  logic         rsp_ready = 1'b0;
  logic         rsp_valid;
  logic [W-1:0] rsp_a;
  logic [W-1:0] rsp_b;
  logic [W-1:0] rsp_gcd;
  logic         busy;
  logic         err;
  logic [15:0]  done_count;

  gcd_requester #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_ready     (req_ready),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .gcd_in_ready  (gcd_in_ready),
    .gcd_in_valid  (gcd_in_valid),
    .gcd_in_a      (gcd_in_a),
    .gcd_in_b      (gcd_in_b),
    .gcd_out_valid (gcd_out_valid),
    .gcd_out_bits  (gcd_out_bits),
    .rsp_ready     (rsp_ready),
    .rsp_valid     (rsp_valid),
    .rsp_a         (rsp_a),
    .rsp_b         (rsp_b),
    .rsp_gcd       (rsp_gcd),
    .busy          (busy),
    .err           (err),
    .done_count    (done_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_done = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pops one response if the model holds any.
  task automatic pop_one();
    check("rsp_valid", rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("rsp_a", rsp_a, q[0].a);
      check("rsp_b", rsp_b, q[0].b);
      check("rsp_gcd", rsp_gcd, q[0].g);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      q.delete(0);
    end
  endtask

  // Full request transaction, playing the engine with a given stall and result latency.
  task automatic do_req(input logic [15:0] a, input logic [15:0] b, input int stall,
                        input int lat);
    exp_t e;
    e.a = a;
    e.b = b;
    e.g = ref_gcd(a, b);
    check("req_ready_pre", req_ready, q.size() < DEPTH);
    req_valid    = 1'b1;
    req_a        = a;
    req_b        = b;
    gcd_in_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    if (a == 0) begin
      q.push_back(e);
      exp_done++;
      check("bypass_no_issue", gcd_in_valid, 1'b0);
      check("bypass_rsp_valid", rsp_valid, 1'b1);
      check("bypass_busy", busy, 1'b0);
      check("bypass_done", done_count, exp_done);
    end else begin
      for (int i = 0; i < stall; i++) begin
        check("stall_in_valid", gcd_in_valid, 1'b1);
        check("stall_ops", {gcd_in_a, gcd_in_b}, {a, b});
        check("stall_req_ready", req_ready, 1'b0);
        check("stall_done", done_count, exp_done);
        @(negedge clock);
      end
      check("issue_in_valid", gcd_in_valid, 1'b1);
      check("issue_ops", {gcd_in_a, gcd_in_b}, {a, b});
      check("issue_busy", busy, 1'b1);
      gcd_in_ready = 1'b1;
      @(negedge clock);
      gcd_in_ready = 1'b0;
      check("wait_in_valid", gcd_in_valid, 1'b0);
      check("wait_req_ready", req_ready, 1'b0);
      repeat (lat) @(negedge clock);
      gcd_out_valid = 1'b1;
      gcd_out_bits  = e.g;
      @(negedge clock);
      gcd_out_valid = 1'b0;
      gcd_out_bits  = 16'($urandom);
      q.push_back(e);
      exp_done++;
      check("eng_busy_after", busy, 1'b0);
      check("eng_rsp_valid", rsp_valid, 1'b1);
      check("eng_done", done_count, exp_done);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] saved_done;

    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_in_valid", gcd_in_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", done_count, 16'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic engine transaction
    do_req(16'd12, 16'd18, 0, 2);
    pop_one();
    check("basic_empty", rsp_valid, 1'b0);

    // Zero bypass then b==0 through engine
    do_req(16'd0, 16'd7, 0, 0);
    do_req(16'd9, 16'd0, 0, 1);
    pop_one();
    pop_one();

    // Engine stall in ISSUE
    do_req(16'd21, 16'd14, 5, 3);
    pop_one();

    // Backpressure: fill the FIFO, fifth request held off
    do_req(16'd4, 16'd6, 0, 0);
    do_req(16'd0, 16'd5, 0, 0);
    do_req(16'd35, 16'd15, 1, 2);
    do_req(16'd100, 16'd75, 0, 1);
    req_valid = 1'b1;
    req_a     = 16'd5;
    req_b     = 16'd10;
    for (int i = 0; i < 3; i++) begin
      check("full_req_ready", req_ready, 1'b0);
      check("full_no_issue", gcd_in_valid, 1'b0);
      check("full_done", done_count, exp_done);
      @(negedge clock);
    end
    req_valid = 1'b0;
    pop_one();
    check("slot_freed_req_ready", req_ready, 1'b1);
    while (q.size() != 0) pop_one();
    check("drained", rsp_valid, 1'b0);

    // Stray result pulse in IDLE
    saved_done    = done_count;
    gcd_out_valid = 1'b1;
    gcd_out_bits  = 16'h1234;
    @(negedge clock);
    gcd_out_valid = 1'b0;
    check("stray_err", err, 1'b1);
    check("stray_no_push", rsp_valid, 1'b0);
    check("stray_done", done_count, saved_done);
    repeat (3) @(negedge clock);
    check("stray_err_sticky", err, 1'b1);

    // Asynchronous reset while in WAIT
    req_valid = 1'b1;
    req_a     = 16'd20;
    req_b     = 16'd30;
    @(negedge clock);
    req_valid    = 1'b0;
    gcd_in_ready = 1'b1;
    @(negedge clock);
    gcd_in_ready = 1'b0;
    check("pre_reset_busy", busy, 1'b1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_valid", gcd_in_valid, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_done", done_count, 16'd0);
    @(negedge clock);
    reset    = 1'b0;
    q.delete();
    exp_done = '0;
    do_req(16'd8, 16'd12, 0, 2);
    pop_one();

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 60) * $urandom_range(1, 40));
      rb = 16'($urandom_range(0, 60) * $urandom_range(1, 40));
      do_req(ra, rb, $urandom_range(0, 3), $urandom_range(0, 4));
      if (q.size() == DEPTH || $urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(1, q.size()); k > 0; k--) pop_one();
      end
    end
    while (q.size() != 0) pop_one();
    check("final_empty", rsp_valid, 1'b0);
    check("final_done", done_count, exp_done);
    check("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
- Initiator side of the GCD engine's operand/result protocol.
- Accepts operand pairs from upstream over ready/valid and drives them into the engine's in_ready/in_valid port.
- Captures the engine's result pulse, which is valid-only and cannot be backpressured, and buffers {a, b, gcd} in a small FIFO for a ready/valid downstream consumer.
- Reserves a FIFO slot before issuing, so a result is never dropped; it also bypasses the a==0 case, which would hang the engine.

Parameters:
- W, 16, operand and result width.
- DEPTH, 4, result FIFO entries; power of 2, ≥2.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high; clears all state.
- req_ready  out  1  upstream may present an operand pair.
- req_valid  in  1  upstream operand pair valid.
- req_a  in  W  operand a.
- req_b  in  W  operand b.
- gcd_in_ready  in  1  engine idle, can accept operands.
- gcd_in_valid  out  1  operands offered to engine.
- gcd_in_a  out  W  operand a to engine.
- gcd_in_b  out  W  operand b to engine.
- gcd_out_valid  in  1  one-cycle result pulse from engine.
- gcd_out_bits  in  W  engine result.
- rsp_ready  in  1  downstream accepts a response.
- rsp_valid  out  1  FIFO head valid.
- rsp_a  out  W  echoed operand a of head.
- rsp_b  out  W  echoed operand b of head.
- rsp_gcd  out  W  result of head.
- busy  out  1  a request is held or in flight (state != IDLE).
- err  out  1  sticky: gcd_out_valid seen outside WAIT.
- done_count  out  16  responses pushed, wraps 0xFFFF->0.

Behaviour:
- Reset values: state=IDLE; FIFO empty (count=0, pointers 0); operand regs 0; err=0; done_count=0. Resulting outputs: req_ready=1, gcd_in_valid=0, rsp_valid=0, busy=0.
- FSM state IDLE:
  - req_ready = (count < DEPTH).
  - On accept (req_valid & req_ready), latch op_a/op_b.
  - If req_a==0: push {req_a, req_b, req_b} into the FIFO at the same edge and stay in IDLE. This includes a=b=0, which pushes {0,0,0}. The engine is never touched.
  - Otherwise go to ISSUE.
- FSM state ISSUE:
  - gcd_in_valid=1, gcd_in_a/b = op_a/op_b (registered, stable while waiting).
  - On gcd_in_ready=1, go to WAIT.
  - First possible gcd_in_valid is the cycle after the accept.
- FSM state WAIT:
  - gcd_in_valid=0.
  - On gcd_out_valid, push {op_a, op_b, gcd_out_bits} and go to IDLE.
  - No timeout: the a!=0 guarantee ensures the engine terminates.
- Slot reservation: acceptance requires count<DEPTH, and only one request is outstanding, so the WAIT push always has space. The push never stalls and no result is lost.
- FIFO:
  - rsp_valid = (count != 0); head outputs come from registered storage.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: count unchanged; a push into an empty FIFO becomes visible the next cycle (no fall-through).
  - Pointers wrap modulo DEPTH.
- Latency:
  - Bypass: accept at edge N, rsp_valid high after edge N.
  - Engine path: rsp_valid high one cycle after the gcd_out_valid edge.
- done_count increments on every push, both bypass and engine.
- Stray gcd_out_valid in IDLE or ISSUE: ignored (no push), err set to 1 and held until reset.
- Reset mid-operation: all state clears immediately and asynchronously, and any in-flight request is discarded. The engine shares the reset, so no stale result returns.
- req_ready is 0 in ISSUE and WAIT; it depends only on state and count, not on req_valid.

Decomposition:
- Package gcd_pkg:
  - W default constant.
  - State enum {IDLE, ISSUE, WAIT}.
  - Struct gcd_rsp_t {a, b, gcd}.
- Sub-module gcd_rsp_fifo:
  - Parameterised by DEPTH, storing gcd_rsp_t.
  - Ports: push/push_data, pop, head, count.
- gcd_requester holds the FSM, operand registers, bypass, err and done_count.

Test Plan:
- Basic: req (12,18), engine returns 6 -> one gcd_in_valid burst with (12,18); rsp = {12,18,6}; done_count=1; busy 0 afterwards.
- Zero bypass: req (0,7) -> gcd_in_valid stays 0; rsp {0,7,7} valid the cycle after accept. Then req (9,0) via the engine -> rsp {9,0,9}.
- Backpressure: rsp_ready=0, four reqs completing -> count=4 and req_ready=0 with a fifth req held. Raise rsp_ready for one cycle -> req_ready=1 the next cycle; responses drain in order.
- Engine stall: gcd_in_ready=0 for 5 cycles in ISSUE -> gcd_in_valid and operands held constant, req_ready=0, no push.
- Stray pulse: gcd_out_valid in IDLE -> err=1 (sticky), count and done_count unchanged.
- Reset mid-WAIT: assert reset between edges -> gcd_in_valid=0, rsp_valid=0, busy=0, err=0, done_count=0 immediately; a new req (8,12) then returns 4.
